// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter with register-file init sequence
module regfile_wb_arbiter #(
    parameter int INIT_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic [2:0]  req_valid,
    input  logic [4:0]  req_rd0,
    input  logic [4:0]  req_rd1,
    input  logic [4:0]  req_rd2,
    input  logic [31:0] req_data0,
    input  logic [31:0] req_data1,
    input  logic [31:0] req_data2,
    output logic [2:0]  req_ready,
    output logic        wer,
    output logic [4:0]  rd,
    output logic [31:0] regdata,
    output logic        init_done
);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_RESET = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    localparam logic [4:0] CNT_FIRST = 5'd1;
    localparam logic [4:0] CNT_LAST  = 5'd31;

    logic [0:0]  state;
    logic [4:0]  cnt;
    logic [1:0]  ptr;

    logic        grant_any;
    logic [1:0]  grant_idx;
    logic [1:0]  cand0;
    logic [1:0]  cand1;
    logic [1:0]  cand2;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;
    logic [1:0]  ptr_next;

    // Add an offset to the pointer modulo 3; both operands are always in 0..2.
    function automatic logic [1:0] rot3(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] sum;
        logic [2:0] wrapped;
        sum     = {1'b0, base} + {1'b0, off};
        wrapped = (sum >= 3'd3) ? (sum - 3'd3) : sum;
        return wrapped[1:0];
    endfunction

    // Candidate order for this cycle: ptr, ptr+1, ptr+2 (mod 3).
    always_comb begin
        cand0 = ptr;
        cand1 = rot3(ptr, 2'd1);
        cand2 = rot3(ptr, 2'd2);
    end

    // Pick the first valid requester in rotation order; only in RUN, unstalled, out of reset.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = ptr;
        if (rst_n && (state == ST_RUN) && !hold) begin
            if (req_valid[cand0]) begin
                grant_any = 1'b1;
                grant_idx = cand0;
            end else if (req_valid[cand1]) begin
                grant_any = 1'b1;
                grant_idx = cand1;
            end else if (req_valid[cand2]) begin
                grant_any = 1'b1;
                grant_idx = cand2;
            end
        end
    end

    // One-hot handshake back to the granted requester in the same cycle.
    always_comb begin
        req_ready = 3'b000;
        if (grant_any) begin
            req_ready = 3'b001 << grant_idx;
        end
    end

    // Route the granted requester's index and data toward the write register.
    always_comb begin
        case (grant_idx)
            2'd0:    begin sel_rd = req_rd0; sel_data = req_data0; end
            2'd1:    begin sel_rd = req_rd1; sel_data = req_data1; end
            default: begin sel_rd = req_rd2; sel_data = req_data2; end
        endcase
    end

    // Pointer moves just past the winner so it gets lowest priority next time.
    always_comb begin
        ptr_next = (grant_idx == 2'd2) ? 2'd0 : (grant_idx + 2'd1);
    end

    // State, init counter, pointer and the registered register-file write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RESET;
            cnt       <= CNT_FIRST;
            ptr       <= 2'd0;
            wer       <= 1'b0;
            rd        <= 5'd0;
            regdata   <= 32'd0;
            init_done <= 1'b0;
        end else begin
            // init_done trails entry into RUN by one cycle.
            init_done <= (state == ST_RUN);
            case (state)
                ST_INIT: begin
                    wer     <= 1'b1;
                    rd      <= cnt;
                    regdata <= {27'd0, cnt};
                    cnt     <= cnt + 5'd1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    if (grant_any) begin
                        // x0 is hardwired: complete the handshake but suppress the write.
                        wer     <= (sel_rd != 5'd0);
                        rd      <= sel_rd;
                        regdata <= sel_data;
                        ptr     <= ptr_next;
                    end else begin
                        wer <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    localparam int INIT_EN = 1;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic [2:0]  req_valid;
    logic [4:0]  req_rd0, req_rd1, req_rd2;
    logic [31:0] req_data0, req_data1, req_data2;
    logic [2:0]  req_ready;
    logic        wer;
    logic [4:0]  rd;
    logic [31:0] regdata;
    logic        init_done;

    logic        p_valid [3];
    logic [4:0]  p_rd    [3];
    logic [31:0] p_data  [3];

    int n_cmp;
    int n_bad;

    // Reference model state
    bit          m_init;
    int          m_cnt;
    int          m_ptr;
    logic        m_wer;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_done;
    int          last_grant;

    regfile_wb_arbiter #(.INIT_EN(INIT_EN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .req_valid (req_valid),
        .req_rd0   (req_rd0),
        .req_rd1   (req_rd1),
        .req_rd2   (req_rd2),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_data2 (req_data2),
        .req_ready (req_ready),
        .wer       (wer),
        .rd        (rd),
        .regdata   (regdata),
        .init_done (init_done)
    );

    assign req_valid = {p_valid[2], p_valid[1], p_valid[0]};
    assign req_rd0   = p_rd[0];
    assign req_rd1   = p_rd[1];
    assign req_rd2   = p_rd[2];
    assign req_data0 = p_data[0];
    assign req_data1 = p_data[1];
    assign req_data2 = p_data[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: check the combinational grant, advance the model across the edge, check registered outputs.
    task automatic cycle();
        int g;
        logic [2:0] exp_ready;
        #1;
        g = -1;
        if (rst_n && !m_init && !hold) begin
            for (int k = 0; k < 3; k++) begin
                int c;
                c = (m_ptr + k) % 3;
                if (g < 0 && p_valid[c]) g = c;
            end
        end
        exp_ready = 3'b000;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", {29'd0, req_ready}, {29'd0, exp_ready});
        last_grant = g;
        @(posedge clk);
        if (!rst_n) begin
            m_init = (INIT_EN != 0);
            m_cnt  = 1;
            m_ptr  = 0;
            m_wer  = 1'b0;
            m_rd   = 5'd0;
            m_data = 32'd0;
            m_done = 1'b0;
        end else begin
            m_done = !m_init;
            if (m_init) begin
                m_wer  = 1'b1;
                m_rd   = 5'(m_cnt);
                m_data = 32'(m_cnt);
                if (m_cnt == 31) m_init = 1'b0;
                m_cnt++;
            end else if (g >= 0) begin
                m_wer  = (p_rd[g] != 5'd0);
                m_rd   = p_rd[g];
                m_data = p_data[g];
                m_ptr  = (g + 1) % 3;
            end else begin
                m_wer = 1'b0;
            end
        end
        #1;
        chk("wer",       {31'd0, wer},       {31'd0, m_wer});
        chk("rd",        {27'd0, rd},        {27'd0, m_rd});
        chk("regdata",   regdata,            m_data);
        chk("init_done", {31'd0, init_done}, {31'd0, m_done});
    endtask

    task automatic set_req(input int k, input logic v, input logic [4:0] r, input logic [31:0] d);
        p_valid[k] = v;
        p_rd[k]    = r;
        p_data[k]  = d;
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < 3; k++) set_req(k, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        logic [2:0] rr_seq [6];
        n_cmp = 0;
        n_bad = 0;
        m_init = (INIT_EN != 0);
        m_cnt = 1; m_ptr = 0; m_wer = 0; m_rd = 0; m_data = 0; m_done = 0;
        rst_n = 1'b0;
        hold  = 1'b0;
        clear_reqs();

        // Reset state, with noise on the request inputs
        for (int i = 0; i < 3; i++) begin
            set_req(i, 1'b1, 5'(i + 3), 32'h100 + 32'(i));
            cycle();
        end

        // Init sequence: 31 writes, requests and hold must be ignored
        rst_n = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            hold = 1'($urandom_range(0, 1));
            cycle();
            chk("init_rd", {27'd0, rd}, 32'(i));
            chk("init_ready", {29'd0, req_ready}, 32'd0);
        end
        hold = 1'b0;
        clear_reqs();
        cycle();
        chk("init_done_high", {31'd0, init_done}, 32'd1);

        // Round robin with all three continuously valid
        rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100;
        rr_seq[3] = 3'b001; rr_seq[4] = 3'b010; rr_seq[5] = 3'b100;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 3; k++) set_req(k, 1'b1, 5'(8 + 3 * i + k), 32'hA000 + 32'(16 * i + k));
            #1;
            chk("rr_seq", {29'd0, req_ready}, {29'd0, rr_seq[i]});
            cycle();
        end
        clear_reqs();

        // Same-rd conflict: ptr is back at 0, req0 writes A then req2 writes B
        set_req(0, 1'b1, 5'd5, 32'hAAAA_0001);
        set_req(2, 1'b1, 5'd5, 32'hBBBB_0002);
        cycle();
        chk("conflict_first", regdata, 32'hAAAA_0001);
        if (last_grant >= 0) p_valid[last_grant] = 1'b0;
        cycle();
        chk("conflict_second", regdata, 32'hBBBB_0002);
        chk("conflict_rd", {27'd0, rd}, 32'd5);
        clear_reqs();

        // Hold stalls a pending request, release grants it
        set_req(1, 1'b1, 5'd12, 32'h1234_5678);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("hold_wer", {31'd0, wer}, 32'd0);
        hold = 1'b0;
        cycle();
        chk("hold_release_rd", {27'd0, rd}, 32'd12);
        clear_reqs();

        // Grant to x0 completes but does not write
        set_req(0, 1'b1, 5'd0, 32'hDEADBEEF);
        cycle();
        chk("x0_wer", {31'd0, wer}, 32'd0);
        chk("x0_data", regdata, 32'hDEADBEEF);
        clear_reqs();
        cycle();

        // Randomized traffic with hold and requesters that keep valid until granted
        for (int i = 0; i < 400; i++) begin
            if (last_grant >= 0) p_valid[last_grant] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (!p_valid[k] && $urandom_range(0, 2) != 0)
                    set_req(k, 1'b1, 5'($urandom_range(0, 31)), $urandom);
            end
            hold = ($urandom_range(0, 3) == 0);
            cycle();
        end
        hold = 1'b0;
        clear_reqs();

        // Reset mid-INIT at write index 10, then full restart
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 20 && m_cnt != 10; i++) cycle();
        chk("midinit_reach", 32'(m_cnt), 32'd10);
        rst_n = 1'b0;
        cycle();
        chk("midinit_wer", {31'd0, wer}, 32'd0);
        rst_n = 1'b1;
        cycle();
        chk("restart_rd", {27'd0, rd}, 32'd1);
        for (int i = 2; i <= 31; i++) begin
            cycle();
            chk("restart_done_low", {31'd0, init_done}, 32'd0);
        end
        cycle();
        chk("restart_done_high", {31'd0, init_done}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter INIT_EN, default 1, meaning: 1 = run register-initialisation sequence after reset, 0 = go straight to arbitration.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 SHALL have port hold  input  1  pipeline stall; when 1, no new grants.
REQ-005 SHALL have ports req_valid[2:0]  input  3  per-requester writeback request (0=ALU, 1=load, 2=CSR).
REQ-006 SHALL have ports req_rd0/1/2  input  5 each  destination register index per requester.
REQ-007 SHALL have ports req_data0/1/2  input  32 each  writeback data per requester.
REQ-008 SHALL have port req_ready[2:0]  output  3  per-requester grant, combinational, one-hot or zero.
REQ-009 SHALL have port wer  output  1  register-file write enable, registered.
REQ-010 SHALL have port rd  output  5  register-file write index, registered.
REQ-011 SHALL have port regdata  output  32  register-file write data, registered.
REQ-012 SHALL have port init_done  output  1  high once arbitration state is reached, registered.

Function
REQ-013 SHALL implement states INIT and RUN; after reset state = INIT if INIT_EN=1, else RUN.
REQ-014 SHALL, in INIT, hold a 5-bit counter starting at 1 and each cycle drive wer=1, rd=cnt, regdata={27'b0,cnt} on the next edge, incrementing cnt.
REQ-015 SHALL leave INIT after the write with cnt=31 (31 writes, indices 1..31); init_done rises the cycle after that write is presented, state = RUN.
REQ-016 SHALL ignore hold and req_valid in INIT; req_ready = 0 throughout INIT.
REQ-017 SHALL, in RUN with hold=0, grant exactly one valid requester per cycle by round-robin starting at pointer ptr (2 bits, values 0..2).
REQ-018 SHALL search ptr, ptr+1, ptr+2 (mod 3) and grant the first with req_valid=1; req_ready bit set combinationally in the same cycle.
REQ-019 SHALL, on a grant to requester k, update ptr to (k+1) mod 3 at the next edge; ptr unchanged when no grant.
REQ-020 SHALL, in RUN with hold=1 or no valid request, drive req_ready=0 and present wer=0 on the next edge.
REQ-021 SHALL, on a grant to k at edge N, present wer=1, rd=req_rdk, regdata=req_datak for exactly the cycle after edge N (1-cycle latency).
REQ-022 SHALL accept a grant whose req_rd = 0 (handshake completes) but present wer=0 for it; rd and regdata still updated.
REQ-023 SHALL hold rd and regdata at last values when wer=0 (no other than REQ-022 updates).
REQ-024 SHALL handle two requesters targeting the same rd in one cycle by granting only one; the other keeps valid and is granted in a later cycle in round-robin order.
REQ-025 SHALL sustain one write per cycle under continuous requests; with all three valid continuously grants rotate 0,1,2,0,...
REQ-026 SHALL keep requester data stable expectation: requester holds valid/rd/data until its req_ready=1 (sampled same cycle).

Reset
REQ-027 SHALL, when rst_n=0 at an edge, set wer=0, rd=0, regdata=0, init_done=0, ptr=0, cnt=1, state per REQ-013; req_ready=0 while rst_n=0.
REQ-028 SHALL, on reset asserted mid-INIT or mid-RUN, abandon the operation; any in-flight write is not presented; INIT restarts from index 1.

Verification
REQ-029 SHALL verify init: INIT_EN=1, release rst_n -> 31 consecutive cycles wer=1 with rd=regdata=1..31, then init_done=1, req_ready stays 0 throughout.
REQ-030 SHALL verify round-robin: after init, req_valid=3'b111 held 6 cycles -> req_ready sequence 001,010,100,001,010,100; wer=1 each following cycle with matching rd/data.
REQ-031 SHALL verify hold: req_valid=3'b010, hold=1 for 3 cycles -> req_ready=0, wer=0; hold drop -> grant to 1, next cycle wer=1, rd=req_rd1.
REQ-032 SHALL verify x0 suppression: req_valid=3'b001, req_rd0=0, req_data0=32'hDEADBEEF -> req_ready=001, next cycle wer=0, rd=0.
REQ-033 SHALL verify same-rd conflict: req0 and req2 both rd=5, data A and B, ptr=0 -> cycle 1 writes A, cycle 2 writes B (final x5=B).
REQ-034 SHALL verify reset mid-INIT: rst_n=0 at write index 10 -> wer=0 next cycle; on release INIT restarts at rd=1, init_done=0 until index 31 written.
